al_accel_obuf_drain: RTL

AL_ACCEL_OBUF_DRAIN -- requirements
Module: al_accel_obuf_drain

---
 rtl/al_accel_pkg.sv | 27 ++
 rtl/al_accel_sync_fifo.sv | 48 ++++
 rtl/al_accel_obuf_drain.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/al_accel_pkg.sv
// Shared types and constants for the accelerator output-buffer drain block.
// Optional feature macro: AL_ACCEL_DRAIN_RELU_EN. When defined, negative words
// (bit 31 set) are written to memory as zero. Otherwise words pass unchanged.
package al_accel_pkg;

  localparam int AL_ACCEL_DATA_W = 32;
  localparam int AL_ACCEL_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;

  // Transform applied to each word as it enters the FIFO (purely combinational)
  function automatic logic [AL_ACCEL_DATA_W-1:0] al_accel_relu(
    input logic [AL_ACCEL_DATA_W-1:0] d
  );
`ifdef AL_ACCEL_DRAIN_RELU_EN
    return d[AL_ACCEL_DATA_W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

endpackage

// File: rtl/al_accel_sync_fifo.sv
// Single-clock word FIFO. The write is registered and dout shows the head combinationally.
// The pointers carry an extra wrap bit so full and empty can be told apart.
module al_accel_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign dout      = r_mem[r_rptr[AW-1:0]];

  // Pointer update. Reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage write. The contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/al_accel_obuf_drain.sv
// Drains result words from the accelerator output buffer into memory write beats.
// Each word is buffered in a small FIFO and then presented on a registered
// valid/ready write port. Addresses start at base_addr and step by ADDR_STRIDE.
// Optional feature macro: AL_ACCEL_DRAIN_RELU_EN. When defined, negative words
// are zeroed as they are pushed, with no added latency.
module al_accel_obuf_drain
  import al_accel_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enb,
  input  logic                       start,
  input  logic [AL_ACCEL_ADDR_W-1:0] base_addr,
  input  logic [15:0]                word_cnt,
  input  logic [AL_ACCEL_DATA_W-1:0] obuf_do,
  input  logic                       obuf_vld,
  output logic                       obuf_rdy,
  output logic [AL_ACCEL_ADDR_W-1:0] mem_addr,
  output logic [AL_ACCEL_DATA_W-1:0] mem_wdata,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf_err
);

  localparam logic [AL_ACCEL_ADDR_W-1:0] STRIDE = AL_ACCEL_ADDR_W'(ADDR_STRIDE);

  drain_state_t               r_state;
  drain_state_t               w_state_nxt;
  logic [15:0]                r_word_cnt;
  logic [15:0]                r_accepted;
  logic [AL_ACCEL_ADDR_W-1:0] r_next_addr;
  logic [AL_ACCEL_ADDR_W-1:0] r_mem_addr;
  logic [AL_ACCEL_DATA_W-1:0] r_mem_wdata;
  logic                       r_mem_valid;
  logic                       r_ovf_err;

  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [AL_ACCEL_DATA_W-1:0] w_fifo_dout;
  logic [AL_ACCEL_DATA_W-1:0] w_fifo_din;
  logic                       w_start_acc;
  logic                       w_want_word;
  logic                       w_rdy;
  logic                       w_push;
  logic                       w_last_push;
  logic                       w_load;
  logic                       w_ovf_set;

  // A start is honoured only in IDLE while enabled. In any other state it is ignored.
  assign w_start_acc = start && enb && (r_state == ST_IDLE);
  // In RUN, enabled, and still owed words. A full FIFO is the only thing left to block a push.
  assign w_want_word = (r_state == ST_RUN) && enb && (r_accepted < r_word_cnt);
  assign w_rdy       = w_want_word && !w_fifo_full;
  assign w_push      = obuf_vld && w_rdy;
  assign w_last_push = w_push && (r_accepted == (r_word_cnt - 16'd1));
  // Back-pressure from a full FIFO is legitimate flow control and does not count as an overflow.
  assign w_ovf_set   = obuf_vld && !w_rdy && !(w_want_word && w_fifo_full);
  // The output register refills as soon as it is empty or its current beat is accepted.
  assign w_load      = !w_fifo_empty && enb && (!r_mem_valid || mem_ready);
  assign w_fifo_din  = al_accel_relu(obuf_do);

  al_accel_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AL_ACCEL_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_load),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic. Everything holds while enb is low.
  always_comb begin
    w_state_nxt = r_state;
    if (enb) begin
      case (r_state)
        ST_IDLE:  if (start) w_state_nxt = (word_cnt != 16'd0) ? ST_RUN : ST_DONE;
        ST_RUN:   if (w_last_push) w_state_nxt = ST_FLUSH;
        ST_FLUSH: if (w_fifo_empty && !r_mem_valid) w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    obuf_rdy = w_rdy;
    busy     = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    done     = (r_state == ST_DONE);
  end

  // Job bookkeeping: latched count, accepted-word counter and next beat address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_cnt  <= '0;
      r_accepted  <= '0;
      r_next_addr <= '0;
    end else if (w_start_acc) begin
      r_word_cnt  <= word_cnt;
      r_accepted  <= '0;
      r_next_addr <= base_addr;
    end else begin
      if (w_push) r_accepted  <= r_accepted + 16'd1;
      if (w_load) r_next_addr <= r_next_addr + STRIDE;
    end
  end

  // Registered write port. A pending beat holds until mem_ready, even while enb is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_load) begin
      r_mem_valid <= 1'b1;
      r_mem_addr  <= r_next_addr;
      r_mem_wdata <= w_fifo_dout;
    end else if (r_mem_valid && mem_ready) begin
      r_mem_valid <= 1'b0;
    end
  end

  // Sticky overflow flag. It is cleared only by a newly accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_ovf_err <= 1'b0;
    else if (w_start_acc) r_ovf_err <= 1'b0;
    else if (w_ovf_set)   r_ovf_err <= 1'b1;
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ovf_err   = r_ovf_err;

endmodule
